// File: rtl/hsi_accel_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hsi_accel_pkg
// Register word offsets, STATUS bit positions and run-state encoding.
// Revision : 1.0
// ============================================================================
package hsi_accel_pkg;

  localparam logic [3:0] c_reg_ctrl    = 4'd0;
  localparam logic [3:0] c_reg_nbands  = 4'd1;
  localparam logic [3:0] c_reg_status  = 4'd2;
  localparam logic [3:0] c_reg_in1     = 4'd3;
  localparam logic [3:0] c_reg_in2     = 4'd4;
  localparam logic [3:0] c_reg_out     = 4'd5;
  localparam logic [3:0] c_reg_irq_en  = 4'd6;
  localparam logic [3:0] c_reg_pix_cnt = 4'd7;

  localparam int c_st_busy      = 0;
  localparam int c_st_done      = 1;
  localparam int c_st_in1_full  = 2;
  localparam int c_st_in2_full  = 3;
  localparam int c_st_res_empty = 4;
  localparam int c_st_err_under = 5;
  localparam int c_st_err_busy  = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_DONE} hsi_run_state_e;

endpackage
`default_nettype wire

// File: rtl/hsi_accel_obi_stream_if.sv
`default_nettype none
// ============================================================================
// Interface : hsi_accel_obi_stream_if
// OBI request/response signals between the SoC bus master and the accelerator.
// Revision  : 1.0
// ============================================================================
interface hsi_accel_obi_stream_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_i;
  logic          gnt_o;
  logic [AW-1:0] addr_i;
  logic          we_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o;
  logic          rvalid_o;

  modport slave  (input  req_i, addr_i, we_i, wdata_i, output gnt_o, rdata_o, rvalid_o);
  modport master (output req_i, addr_i, we_i, wdata_i, input  gnt_o, rdata_o, rvalid_o);
endinterface
`default_nettype wire

// File: rtl/hsi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hsi_sync_fifo
// Single-clock FIFO with flush; the head reads as zero while empty.
// Revision : 1.0
// ============================================================================
module hsi_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  input  wire logic         flush_i,
  input  wire logic         push_i,
  input  wire logic [W-1:0] wdata_i,
  input  wire logic         pop_i,
  output logic      [W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int c_ptr_w = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [c_ptr_w:0] r_wr_ptr;
  logic [c_ptr_w:0] r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                   (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : r_mem[r_rd_ptr[c_ptr_w-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/hsi_accel_obi_stream.sv
`default_nettype none
// ============================================================================
// Module   : hsi_accel_obi_stream
// OBI slave front end for the HSI vector core: CSRs, operand/result FIFOs, run FSM, IRQ.
// Revision : 1.0
// ============================================================================
module hsi_accel_obi_stream
  import hsi_accel_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int EW    = 16,
  parameter int DEPTH = 8,
  parameter int OPW   = 2
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  hsi_accel_obi_stream_if.slave obi,
  output logic                 core_start_o,
  output logic      [OPW-1:0]  core_op_code_o,
  output logic      [15:0]     core_num_bands_o,
  output logic                 in1_valid_o,
  output logic      [EW-1:0]   in1_data_o,
  input  wire logic            in1_ready_i,
  output logic                 in2_valid_o,
  output logic      [EW-1:0]   in2_data_o,
  input  wire logic            in2_ready_i,
  input  wire logic            res_valid_i,
  input  wire logic [EW-1:0]   res_data_i,
  output logic                 res_ready_o,
  input  wire logic            pixel_done_i,
  input  wire logic            core_busy_i,
  output logic                 irq_o
);
  hsi_run_state_e r_state, w_state_nxt;

  logic [3:0]     w_idx;
  logic           w_acc, w_wr, w_rd, w_ctrl_wr, w_clr, w_start, w_start_ok;
  logic           w_in1_full, w_in1_empty, w_in2_full, w_in2_empty;
  logic           w_res_full, w_res_empty, w_pop_out;
  logic [EW-1:0]  w_res_data;
  logic [6:0]     w_status;
  logic [DW-1:0]  w_rmux;
  logic           w_unused;

  logic           r_alive, r_rvalid, r_irq_en, r_done, r_err_under, r_err_busy;
  logic [DW-1:0]  r_rdata;
  logic [OPW-1:0] r_op, r_core_op;
  logic [15:0]    r_num_bands, r_core_nb;
  logic [31:0]    r_pix_cnt;

  assign w_unused = ^{obi.addr_i[AW-1:6], obi.addr_i[1:0], obi.wdata_i[DW-1:16]};
  assign w_idx    = obi.addr_i[5:2];

  // Only a push into a full operand FIFO withholds the grant.
  assign obi.gnt_o = obi.req_i &
                     ~(obi.we_i & (w_idx == c_reg_in1) & w_in1_full) &
                     ~(obi.we_i & (w_idx == c_reg_in2) & w_in2_full);
  assign w_acc     = obi.gnt_o;
  assign w_wr      = w_acc & obi.we_i;
  assign w_rd      = w_acc & ~obi.we_i;
  assign w_pop_out = w_rd & (w_idx == c_reg_out);

  assign w_ctrl_wr  = w_wr & (w_idx == c_reg_ctrl);
  assign w_clr      = w_ctrl_wr & obi.wdata_i[1];
  assign w_start    = w_ctrl_wr & obi.wdata_i[0] & ~obi.wdata_i[1];
  assign w_start_ok = w_start & (r_state == ST_IDLE) & (r_num_bands != '0);

  assign obi.rvalid_o     = r_rvalid;
  assign obi.rdata_o      = r_rdata;
  assign core_op_code_o   = r_core_op;
  assign core_num_bands_o = r_core_nb;
  assign in1_valid_o      = ~w_in1_empty;
  assign in2_valid_o      = ~w_in2_empty;
  assign res_ready_o      = r_alive & ~w_res_full;
  assign irq_o            = r_done & r_irq_en;

  always_comb begin
    w_status                 = '0;
    w_status[c_st_busy]      = (r_state != ST_IDLE) | core_busy_i;
    w_status[c_st_done]      = r_done;
    w_status[c_st_in1_full]  = w_in1_full;
    w_status[c_st_in2_full]  = w_in2_full;
    w_status[c_st_res_empty] = w_res_empty;
    w_status[c_st_err_under] = r_err_under;
    w_status[c_st_err_busy]  = r_err_busy;
  end

  always_comb begin
    w_rmux = '0;
    case (w_idx)
      c_reg_ctrl:    w_rmux[OPW+1:2] = r_op;
      c_reg_nbands:  w_rmux[15:0]    = r_num_bands;
      c_reg_status:  w_rmux[6:0]     = w_status;
      c_reg_out:     w_rmux[EW-1:0]  = w_res_data;
      c_reg_irq_en:  w_rmux[0]       = r_irq_en;
      c_reg_pix_cnt: w_rmux[31:0]    = r_pix_cnt;
      default:       w_rmux          = '0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    core_start_o = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_START;
      ST_START: begin
        core_start_o = 1'b1;
        w_state_nxt  = ST_RUN;
      end
      ST_RUN:   if (pixel_done_i) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_clr) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alive     <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_op        <= '0;
      r_num_bands <= '0;
      r_irq_en    <= 1'b0;
      r_pix_cnt   <= '0;
      r_core_op   <= '0;
      r_core_nb   <= '0;
      r_done      <= 1'b0;
      r_err_under <= 1'b0;
      r_err_busy  <= 1'b0;
    end else begin
      r_alive  <= 1'b1;
      r_rvalid <= w_acc;
      r_rdata  <= w_rd ? w_rmux : '0;
      if (w_ctrl_wr) r_op <= obi.wdata_i[OPW+1:2];
      if (w_wr && w_idx == c_reg_nbands) r_num_bands <= obi.wdata_i[15:0];
      if (w_wr && w_idx == c_reg_irq_en) r_irq_en <= obi.wdata_i[0];
      if (pixel_done_i) r_pix_cnt <= r_pix_cnt + 1'b1;
      // Op comes from the same write that starts the run.
      if (w_start_ok) begin
        r_core_op <= obi.wdata_i[OPW+1:2];
        r_core_nb <= r_num_bands;
      end
      if (w_clr) begin
        r_done      <= 1'b0;
        r_err_under <= 1'b0;
        r_err_busy  <= 1'b0;
      end else begin
        if (r_state == ST_DONE)                  r_done      <= 1'b1;
        if (w_pop_out && w_res_empty)            r_err_under <= 1'b1;
        if (w_start && (r_state != ST_IDLE))     r_err_busy  <= 1'b1;
      end
    end
  end

  hsi_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_in1_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (w_clr),
    .push_i  (w_wr & (w_idx == c_reg_in1)),
    .wdata_i (obi.wdata_i[EW-1:0]),
    .pop_i   (in1_ready_i),
    .rdata_o (in1_data_o),
    .full_o  (w_in1_full),
    .empty_o (w_in1_empty)
  );

  hsi_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_in2_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (w_clr),
    .push_i  (w_wr & (w_idx == c_reg_in2)),
    .wdata_i (obi.wdata_i[EW-1:0]),
    .pop_i   (in2_ready_i),
    .rdata_o (in2_data_o),
    .full_o  (w_in2_full),
    .empty_o (w_in2_empty)
  );

  hsi_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_res_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (w_clr),
    .push_i  (res_valid_i & res_ready_o),
    .wdata_i (res_data_i),
    .pop_i   (w_pop_out),
    .rdata_o (w_res_data),
    .full_o  (w_res_full),
    .empty_o (w_res_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_hsi_accel_obi_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsi_accel_obi_stream
// Directed bench for hsi_accel_obi_stream with hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_hsi_accel_obi_stream;
  import hsi_accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_start, in1_valid, in2_valid, in1_ready, in2_ready;
  logic        res_valid, res_ready, pixel_done, core_busy, irq;
  logic [1:0]  core_op;
  logic [15:0] core_nb, in1_data, in2_data, res_data;
  int          errors = 0;
  int          checks = 0;
  int          n_starts = 0;

  hsi_accel_obi_stream_if #(.AW(32), .DW(32)) obi_bus ();

  hsi_accel_obi_stream #(.AW(32), .DW(32), .EW(16), .DEPTH(8), .OPW(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .obi              (obi_bus),
    .core_start_o     (core_start),
    .core_op_code_o   (core_op),
    .core_num_bands_o (core_nb),
    .in1_valid_o      (in1_valid),
    .in1_data_o       (in1_data),
    .in1_ready_i      (in1_ready),
    .in2_valid_o      (in2_valid),
    .in2_data_o       (in2_data),
    .in2_ready_i      (in2_ready),
    .res_valid_i      (res_valid),
    .res_data_i       (res_data),
    .res_ready_o      (res_ready),
    .pixel_done_i     (pixel_done),
    .core_busy_i      (core_busy),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start === 1'b1) n_starts++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the response cycle.
  task automatic bus_xfer(input logic [3:0] idx, input logic we, input logic [31:0] wd,
                          output logic [31:0] rd);
    int n;
    n = 0;
    obi_bus.req_i   = 1'b1;
    obi_bus.addr_i  = {26'd0, idx, 2'b00};
    obi_bus.we_i    = we;
    obi_bus.wdata_i = wd;
    #1;
    while (obi_bus.gnt_o !== 1'b1 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) begin
      chk("gnt_timeout", {31'd0, obi_bus.gnt_o}, 32'd1);
      obi_bus.req_i = 1'b0;
      rd = '0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    obi_bus.req_i = 1'b0;
    chk("rvalid", {31'd0, obi_bus.rvalid_o}, 32'd1);
    rd = obi_bus.rdata_o;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_xfer(idx, 1'b1, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    bus_xfer(idx, 1'b0, 32'd0, d);
    chk(tag, d, exp);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {25'd0, obi_bus.gnt_o, obi_bus.rvalid_o, core_start, in1_valid,
                        in2_valid, res_ready, irq}, 32'd0);
    chk({tag, "_data"}, {in1_data, in2_data}, 32'd0);
    chk({tag, "_core"}, {14'd0, core_op, core_nb}, 32'd0);
    chk({tag, "_rdata"}, obi_bus.rdata_o, 32'd0);
  endtask

  initial begin
    obi_bus.req_i = 1'b0; obi_bus.addr_i = '0; obi_bus.we_i = 1'b0; obi_bus.wdata_i = '0;
    in1_ready = 1'b0; in2_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    pixel_done = 1'b0; core_busy = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("res_ready_idle", {31'd0, res_ready}, 32'd1);
    rd_chk("status_reset", c_reg_status, 32'h10);
    rd_chk("pixcnt_reset", c_reg_pix_cnt, 32'd0);

    // Full pixel run: NUM_BANDS=4, OP=2
    wr(c_reg_nbands, 32'd4);
    rd_chk("nbands_rb", c_reg_nbands, 32'd4);
    wr(c_reg_ctrl, 32'h9);
    chk("start_pulse", {31'd0, core_start}, 32'd1);
    chk("core_op", {30'd0, core_op}, 32'd2);
    chk("core_nb", {16'd0, core_nb}, 32'd4);
    @(posedge clk); #1;
    chk("start_pulse_end", {31'd0, core_start}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wr(c_reg_in1, 32'h11 + 32'(i));
      wr(c_reg_in2, 32'h21 + 32'(i));
    end
    chk("in_valid", {30'd0, in1_valid, in2_valid}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("in1_head", {16'd0, in1_data}, 32'h11 + 32'(i));
      chk("in2_head", {16'd0, in2_data}, 32'h21 + 32'(i));
      in1_ready = 1'b1; in2_ready = 1'b1;
      res_valid = 1'b1; res_data = 16'hA001 + 16'(i);
      @(posedge clk); #1;
    end
    in1_ready = 1'b0; in2_ready = 1'b0; res_valid = 1'b0;
    chk("in_drained", {30'd0, in1_valid, in2_valid}, 32'd0);
    rd_chk("status_run", c_reg_status, 32'h01);
    pixel_done = 1'b1;
    @(posedge clk); #1;
    pixel_done = 1'b0;
    @(posedge clk); #1;
    rd_chk("status_done", c_reg_status, 32'h02);
    rd_chk("pixcnt_1", c_reg_pix_cnt, 32'd1);
    chk("one_start", n_starts, 32'd1);
    for (int i = 0; i < 4; i++) rd_chk("out_data", c_reg_out, 32'hA001 + 32'(i));

    // Underflow, IRQ, then CLR
    rd_chk("out_empty", c_reg_out, 32'd0);
    rd_chk("status_under", c_reg_status, 32'h32);
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    wr(c_reg_irq_en, 32'd1);
    chk("irq_on", {31'd0, irq}, 32'd1);
    wr(c_reg_in1, 32'h55);
    chk("in1_before_clr", {31'd0, in1_valid}, 32'd1);
    wr(c_reg_ctrl, 32'h2);
    chk("irq_after_clr", {31'd0, irq}, 32'd0);
    chk("in1_after_clr", {31'd0, in1_valid}, 32'd0);
    rd_chk("status_clr", c_reg_status, 32'h10);
    rd_chk("pixcnt_kept", c_reg_pix_cnt, 32'd1);

    // Back-pressure on a full IN1
    for (int i = 0; i < 8; i++) wr(c_reg_in1, 32'h100 + 32'(i));
    obi_bus.req_i = 1'b1; obi_bus.addr_i = {26'd0, c_reg_in1, 2'b00};
    obi_bus.we_i = 1'b1; obi_bus.wdata_i = 32'h1FF;
    #1;
    chk("gnt_full", {31'd0, obi_bus.gnt_o}, 32'd0);
    @(posedge clk); #2;
    chk("gnt_full_hold", {31'd0, obi_bus.gnt_o}, 32'd0);
    in1_ready = 1'b1;
    @(posedge clk); #1;
    in1_ready = 1'b0;
    #1;
    chk("gnt_after_pop", {31'd0, obi_bus.gnt_o}, 32'd1);
    @(posedge clk); #1;
    obi_bus.req_i = 1'b0;
    chk("rvalid_after_stall", {31'd0, obi_bus.rvalid_o}, 32'd1);
    chk("rdata_on_write", obi_bus.rdata_o, 32'd0);
    @(posedge clk); #1;
    chk("rvalid_single", {31'd0, obi_bus.rvalid_o}, 32'd0);
    chk("in1_head_after_pop", {16'd0, in1_data}, 32'h101);
    rd_chk("status_in1_full", c_reg_status, 32'h14);
    wr(c_reg_ctrl, 32'h2);

    // START with NUM_BANDS=0 is ignored; START during a run flags ERR_BUSY
    wr(c_reg_nbands, 32'd0);
    wr(c_reg_ctrl, 32'h1);
    rd_chk("status_nb0", c_reg_status, 32'h10);
    chk("no_start_nb0", n_starts, 32'd1);
    wr(c_reg_nbands, 32'd3);
    wr(c_reg_ctrl, 32'h5);
    wr(c_reg_ctrl, 32'h1);
    rd_chk("status_err_busy", c_reg_status, 32'h51);
    chk("starts_run2", n_starts, 32'd2);
    chk("core_op_run2", {14'd0, core_op, core_nb}, 32'h10003);
    pixel_done = 1'b1;
    @(posedge clk); #1;
    pixel_done = 1'b0;
    @(posedge clk); #1;
    chk("irq_run_done", {31'd0, irq}, 32'd1);
    rd_chk("pixcnt_2", c_reg_pix_cnt, 32'd2);

    // Asynchronous reset in the middle of a run
    wr(c_reg_ctrl, 32'h2);
    wr(c_reg_ctrl, 32'h1);
    wr(c_reg_in1, 32'h77);
    chk("in1_before_rst", {31'd0, in1_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    rd_chk("status_after_rst", c_reg_status, 32'h10);
    rd_chk("pixcnt_after_rst", c_reg_pix_cnt, 32'd0);

    // pixel_done while idle counts but does not set DONE
    pixel_done = 1'b1;
    @(posedge clk); #1;
    pixel_done = 1'b0;
    rd_chk("pixcnt_idle", c_reg_pix_cnt, 32'd1);
    rd_chk("status_idle_pix", c_reg_status, 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
